axiline_inference_sequencer: RTL
================================

Name: axiline_inference_sequencer

Overview:
- Controller that sequences one accelerator_unit-style inference datapath over a batch of samples.
- Each sample is a dot product split into numChunk chunks of `size` elements.
- Per chunk it issues reads to the x/w feature buffers and drives the datapath's sel and comb_valid, aligned to the buffer's 1-cycle read latency.
- After the pipeline latency it captures data_out_r and presents it on a ready/valid result port; it sits between the batch DMA/host control and the datapath.

Parameters:
- bitwidth, 32, datapath result width (data_out_r).
- size, 10, elements per chunk (informational; sizes nothing here).
- numChunk, 25, chunks per sample; must be >= 1.
- logNumChunk, 5, chunk counter width; must satisfy 2^logNumChunk >= numChunk.
- pipeLatency, 3, cycles from the last chunk at the datapath input (comb_valid high) to a valid data_out_r; must be >= 1.
- addrWidth, 16, buffer address width.
- sampleWidth, 16, sample count/index width.

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-low reset; 0 resets all state.
- start, in, 1, single-cycle batch start pulse; honoured only in IDLE.
- num_samples, in, sampleWidth, samples in the batch; sampled on an accepted start.
- base_addr, in, addrWidth, first buffer address; sampled on an accepted start.
- busy, out, 1, high in any state except IDLE.
- done, out, 1, one-cycle pulse when the batch completes.
- buf_rd_en, out, 1, buffer read strobe; read data is valid one cycle later.
- buf_rd_addr, out, addrWidth, buffer read address.
- acc_sel, out, 1, datapath sel: 0 = first chunk (load), 1 = accumulate.
- acc_comb_valid, out, 1, high on the cycle the last chunk of a sample is at the datapath input.
- acc_data_out_r, in, bitwidth, datapath result.
- result_valid, out, 1, result holding register full.
- result_ready, in, 1, consumer accepts the result.
- result_data, out, bitwidth, captured result.
- result_idx, out, sampleWidth, index of the sample in result_data (0-based).

Behaviour:
- Reset values: every output 0; FSM returns to IDLE; all counters 0. Reset asserted mid-batch aborts immediately, with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, HOLD, FINISH.
- IDLE:
  - start with num_samples > 0 latches num_samples and base_addr, clears the sample and chunk counters, and goes to ISSUE.
  - start with num_samples = 0 goes to FINISH.
  - start is ignored in every other state.
- ISSUE:
  - Every cycle: buf_rd_en = 1, buf_rd_addr = base_addr + sample*numChunk + chunk, computed as a running pointer incremented by 1 and wrapping mod 2^addrWidth.
  - After numChunk cycles, go to DRAIN.
- Alignment registers: acc_sel and acc_comb_valid are registered versions of the issue-cycle values, so they line up with the buffer data.
  - acc_sel = 0 for chunk 0 of a sample, 1 for chunks 1..numChunk-1.
  - acc_comb_valid = 1 only for chunk numChunk-1.
  - With numChunk = 1, a single cycle has acc_sel = 0 and acc_comb_valid = 1.
  - Both outputs are 0 whenever no chunk is presented.
- DRAIN:
  - Counts pipeLatency cycles starting the cycle after acc_comb_valid is high.
  - On the cycle when the count reaches pipeLatency, captures acc_data_out_r into result_data, sets result_valid, sets result_idx = sample, and goes to HOLD.
  - Capture cycle = (cycle with acc_comb_valid = 1) + pipeLatency.
- HOLD:
  - Waits for result_valid & result_ready; result_data and result_idx stay stable until then.
  - On the handshake: result_valid falls next cycle and sample increments.
  - If sample was num_samples-1, go to FINISH; otherwise go to ISSUE. The next sample's first read is issued in the cycle after the handshake.
  - If result_ready is already high on the entry cycle, the handshake completes on that cycle.
- FINISH: done = 1 for one cycle, then IDLE. busy falls together with the transition to IDLE.
- No overlap between samples: at most one sample is in the datapath, which avoids accumulator collisions.
- Cycles per sample, with ready held high = numChunk + 1 + pipeLatency + 1.

Test Plan:
1. Defaults, base_addr=0x0100, num_samples=1, ready=1:
   - Reads cover addresses 0x0100..0x0118 over 25 consecutive cycles.
   - acc_sel is 0 only on the first aligned cycle; acc_comb_valid is high only on the 25th.
   - result is captured 3 cycles after acc_comb_valid, result_idx = 0.
   - done pulses once.
2. num_samples=3, result_ready held low for 10 cycles on sample 1:
   - result_data and result_idx stay stable; no reads are issued during the stall.
   - Sample 2's reads start at base+50 the cycle after the handshake.
3. base_addr=0xFFF0, num_samples=2: addresses wrap 0xFFFF -> 0x0000 with no gaps.
4. num_samples=0: done pulses exactly 2 cycles after start; buf_rd_en and result_valid never assert.
5. numChunk=1, pipeLatency=1:
   - acc_sel=0 and acc_comb_valid=1 on the same cycle.
   - Capture follows one cycle later.
   - A second start pulsed mid-batch is ignored.
6. rst driven low during DRAIN of sample 1 (asynchronous, mid-cycle):
   - All outputs go to 0 immediately and no done pulse appears.
   - After release, a new start runs cleanly from base_addr.

Source files
------------

// File: rtl/axiline_inference_sequencer.sv
// Batch sequencer for an accumulate-style inference datapath: issues per-chunk buffer reads,
// aligns sel/comb_valid with the buffer latency, and hands each sample's result out on ready/valid.
module axiline_inference_sequencer #(
  parameter int unsigned bitwidth    = 32,
  parameter int unsigned size        = 10,
  parameter int unsigned numChunk    = 25,
  parameter int unsigned logNumChunk = 5,
  parameter int unsigned pipeLatency = 3,
  parameter int unsigned addrWidth   = 16,
  parameter int unsigned sampleWidth = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [sampleWidth-1:0] num_samples,
  input  logic [addrWidth-1:0]   base_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   buf_rd_en,
  output logic [addrWidth-1:0]   buf_rd_addr,
  output logic                   acc_sel,
  output logic                   acc_comb_valid,
  input  logic [bitwidth-1:0]    acc_data_out_r,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [bitwidth-1:0]    result_data,
  output logic [sampleWidth-1:0] result_idx
);

  localparam int unsigned DrainWidth = (pipeLatency > 1) ? $clog2(pipeLatency + 1) : 1;
  localparam logic [logNumChunk-1:0] LastChunk = logNumChunk'(numChunk - 1);
  localparam logic [DrainWidth-1:0]  LastDrain = DrainWidth'(pipeLatency);

  if (numChunk < 1 || pipeLatency < 1 || size < 1 ||
      (64'(1) << logNumChunk) < 64'(numChunk)) begin : g_param_check
    $error("axiline_inference_sequencer: invalid parameter set");
  end

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StHold,
    StFinish
  } state_e;

  state_e                 state_q;
  logic [sampleWidth-1:0] num_q;
  logic [sampleWidth-1:0] sample_q;
  logic [logNumChunk-1:0] chunk_q;
  logic [DrainWidth-1:0]  drain_q;
  logic [addrWidth-1:0]   next_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      num_q          <= '0;
      sample_q       <= '0;
      chunk_q        <= '0;
      drain_q        <= '0;
      next_addr_q    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      buf_rd_en      <= 1'b0;
      buf_rd_addr    <= '0;
      acc_sel        <= 1'b0;
      acc_comb_valid <= 1'b0;
      result_valid   <= 1'b0;
      result_data    <= '0;
      result_idx     <= '0;
    end else begin
      done           <= 1'b0;
      acc_sel        <= 1'b0;
      acc_comb_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy <= 1'b1;
            if (num_samples != '0) begin
              num_q       <= num_samples;
              sample_q    <= '0;
              chunk_q     <= '0;
              buf_rd_en   <= 1'b1;
              buf_rd_addr <= base_addr;
              state_q     <= StIssue;
            end else begin
              state_q <= StFinish;
            end
          end
        end
        StIssue: begin
          // Registered one cycle so sel/comb_valid meet the buffer's read data.
          acc_sel        <= (chunk_q != '0);
          acc_comb_valid <= (chunk_q == LastChunk);
          if (chunk_q == LastChunk) begin
            chunk_q     <= '0;
            drain_q     <= '0;
            next_addr_q <= buf_rd_addr + 1'b1;
            buf_rd_en   <= 1'b0;
            buf_rd_addr <= '0;
            state_q     <= StDrain;
          end else begin
            chunk_q     <= chunk_q + 1'b1;
            buf_rd_addr <= buf_rd_addr + 1'b1;
          end
        end
        StDrain: begin
          if (drain_q == LastDrain) begin
            result_data  <= acc_data_out_r;
            result_idx   <= sample_q;
            result_valid <= 1'b1;
            state_q      <= StHold;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        StHold: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            sample_q     <= sample_q + 1'b1;
            if (sample_q == num_q - 1'b1) begin
              state_q <= StFinish;
            end else begin
              buf_rd_en   <= 1'b1;
              buf_rd_addr <= next_addr_q;
              state_q     <= StIssue;
            end
          end
        end
        StFinish: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
